// File: rtl/ex_alu_if.sv
// rtl/ex_alu_if.sv - operation/result handshake bundle for the execute-stage ALU
interface ex_alu_if #(
    parameter int XLEN = 32
);
    logic            i_valid;
    logic            o_ready;
    logic [3:0]      i_alu_ctrl;
    logic [XLEN-1:0] i_op_a;
    logic [XLEN-1:0] i_op_b;
    logic            o_valid;
    logic            i_ready;
    logic [XLEN-1:0] o_result;
    logic            o_zero;
    logic            o_illegal;

    modport master (
        output i_valid, i_alu_ctrl, i_op_a, i_op_b, i_ready,
        input  o_ready, o_valid, o_result, o_zero, o_illegal
    );

    modport slave (
        input  i_valid, i_alu_ctrl, i_op_a, i_op_b, i_ready,
        output o_ready, o_valid, o_result, o_zero, o_illegal
    );
endinterface

// File: rtl/ex_alu.sv
// rtl/ex_alu.sv - RV32I execute ALU with single-cycle logic/arith and bit-serial shifter
module ex_alu #(
    parameter int XLEN = 32
) (
    input logic     i_clk,
    input logic     i_rst,
    ex_alu_if.slave alu
);
    localparam int SHW = $clog2(XLEN);

    typedef enum logic [3:0] {
        OP_ADD     = 4'b0000,
        OP_SUB     = 4'b1000,
        OP_SLL     = 4'b0001,
        OP_SLT     = 4'b0010,
        OP_SLTU    = 4'b0011,
        OP_XOR     = 4'b0100,
        OP_SRL     = 4'b0101,
        OP_SRA     = 4'b1101,
        OP_OR      = 4'b0110,
        OP_AND     = 4'b0111,
        OP_INVALID = 4'b1111
    } alu_op_t;

    typedef enum logic [1:0] {
        SH_LL,
        SH_RL,
        SH_RA
    } shift_kind_t;

    typedef enum logic {
        ST_IDLE,
        ST_SHIFT
    } state_t;

    state_t          state_q, state_d;
    logic [SHW-1:0]  count_q, count_d;
    logic [XLEN-1:0] work_q, work_d;
    shift_kind_t     kind_q, kind_d;
    logic            valid_q, valid_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            zero_q, zero_d;
    logic            illegal_q, illegal_d;

    alu_op_t         op;
    logic [SHW-1:0]  shamt;
    logic [XLEN-1:0] imm_result;
    logic            imm_illegal;
    logic            is_shift;
    shift_kind_t     imm_kind;
    logic [XLEN-1:0] work_step;
    logic            ready;
    logic            accept;

    assign op     = alu_op_t'(alu.i_alu_ctrl);
    assign shamt  = alu.i_op_b[SHW-1:0];
    // Output register can drain and refill on the same edge, so ready looks at i_ready.
    assign ready  = (state_q == ST_IDLE) && (!valid_q || alu.i_ready);
    assign accept = alu.i_valid && ready;

    // Single-cycle result; shifts pass op_a through so a zero shamt completes immediately.
    always_comb begin
        imm_result  = '0;
        imm_illegal = 1'b0;
        is_shift    = 1'b0;
        imm_kind    = SH_LL;
        case (op)
            OP_ADD:  imm_result = alu.i_op_a + alu.i_op_b;
            OP_SUB:  imm_result = alu.i_op_a - alu.i_op_b;
            OP_SLT:  imm_result = {{(XLEN-1){1'b0}}, $signed(alu.i_op_a) < $signed(alu.i_op_b)};
            OP_SLTU: imm_result = {{(XLEN-1){1'b0}}, alu.i_op_a < alu.i_op_b};
            OP_XOR:  imm_result = alu.i_op_a ^ alu.i_op_b;
            OP_OR:   imm_result = alu.i_op_a | alu.i_op_b;
            OP_AND:  imm_result = alu.i_op_a & alu.i_op_b;
            OP_SLL: begin
                imm_result = alu.i_op_a;
                is_shift   = 1'b1;
                imm_kind   = SH_LL;
            end
            OP_SRL: begin
                imm_result = alu.i_op_a;
                is_shift   = 1'b1;
                imm_kind   = SH_RL;
            end
            OP_SRA: begin
                imm_result = alu.i_op_a;
                is_shift   = 1'b1;
                imm_kind   = SH_RA;
            end
            default: imm_illegal = 1'b1;
        endcase
    end

    // One-bit step of the iterative shifter.
    always_comb begin
        work_step = work_q;
        case (kind_q)
            SH_LL:   work_step = {work_q[XLEN-2:0], 1'b0};
            SH_RL:   work_step = {1'b0, work_q[XLEN-1:1]};
            SH_RA:   work_step = {work_q[XLEN-1], work_q[XLEN-1:1]};
            default: work_step = work_q;
        endcase
    end

    // Next-state and output-register update for the IDLE/SHIFT controller.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        work_d    = work_q;
        kind_d    = kind_q;
        valid_d   = valid_q;
        result_d  = result_q;
        zero_d    = zero_q;
        illegal_d = illegal_q;

        if (valid_q && alu.i_ready) begin
            valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (is_shift && (shamt != '0)) begin
                        work_d  = alu.i_op_a;
                        count_d = shamt;
                        kind_d  = imm_kind;
                        state_d = ST_SHIFT;
                    end else begin
                        result_d  = imm_result;
                        zero_d    = (imm_result == '0);
                        illegal_d = imm_illegal;
                        valid_d   = 1'b1;
                    end
                end
            end
            ST_SHIFT: begin
                work_d  = work_step;
                count_d = count_q - SHW'(1);
                if (count_q == SHW'(1)) begin
                    result_d  = work_step;
                    zero_d    = (work_step == '0);
                    illegal_d = 1'b0;
                    valid_d   = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            work_q    <= '0;
            kind_q    <= SH_LL;
            valid_q   <= 1'b0;
            result_q  <= '0;
            zero_q    <= 1'b1;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            work_q    <= work_d;
            kind_q    <= kind_d;
            valid_q   <= valid_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            illegal_q <= illegal_d;
        end
    end

    assign alu.o_ready   = ready;
    assign alu.o_valid   = valid_q;
    assign alu.o_result  = result_q;
    assign alu.o_zero    = zero_q;
    assign alu.o_illegal = illegal_q;
endmodule

// File: tb/tb_ex_alu.sv
// tb/tb_ex_alu.sv - scoreboard bench for ex_alu with directed and random operations
module tb_ex_alu;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    ex_alu_if #(.XLEN(32)) bus ();

    ex_alu #(.XLEN(32)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .alu   (bus)
    );

    typedef struct {
        logic [31:0] res;
        logic        zero;
        logic        ill;
        int          acc;
        int          lat;
    } exp_t;

    exp_t sb[$];
    bit   head_seen  = 1'b0;
    bit   rand_ready = 1'b0;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [32:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int unsigned sh;
        sh = int'(b[4:0]);
        case (op)
            4'b0000: return {1'b0, a + b};
            4'b1000: return {1'b0, a - b};
            4'b0001: return {1'b0, a << sh};
            4'b0010: return {1'b0, ($signed(a) < $signed(b)) ? 32'd1 : 32'd0};
            4'b0011: return {1'b0, (a < b) ? 32'd1 : 32'd0};
            4'b0100: return {1'b0, a ^ b};
            4'b0101: return {1'b0, a >> sh};
            4'b1101: return {1'b0, 32'($signed(a) >>> sh)};
            4'b0110: return {1'b0, a | b};
            4'b0111: return {1'b0, a & b};
            default: return {1'b1, 32'h0};
        endcase
    endfunction

    function automatic int exp_latency(input logic [3:0] op, input logic [31:0] b);
        if (op == 4'b0001 || op == 4'b0101 || op == 4'b1101) return int'(b[4:0]) + 1;
        return 1;
    endfunction

    // Issue one operation; called at posedge+1, returns at posedge+1 after the accept edge.
    task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, output int waited);
        exp_t        e;
        logic [32:0] m;
        bus.i_valid    = 1'b1;
        bus.i_alu_ctrl = op;
        bus.i_op_a     = a;
        bus.i_op_b     = b;
        waited         = 0;
        while (1) begin
            @(negedge clk);
            if (bus.o_ready) break;
            waited++;
            if (waited >= 200) break;
        end
        if (waited >= 200) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: o_ready low for %0d cycles, required 1", waited);
            bus.i_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        m      = model(op, a, b);
        e.res  = m[31:0];
        e.ill  = m[32];
        e.zero = (m[31:0] == 32'h0);
        e.acc  = cyc;
        e.lat  = exp_latency(op, b);
        sb.push_back(e);
        bus.i_valid    = 1'b0;
        bus.i_alu_ctrl = 4'($urandom);
        bus.i_op_a     = $urandom;
        bus.i_op_b     = $urandom;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: compares the presented result against the scoreboard head every cycle it is valid.
    always @(negedge clk) begin
        if (!rst && bus.o_valid) begin
            if (sb.size() == 0) begin
                chk("spurious_valid", 32'(bus.o_valid), 32'd0);
            end else begin
                if (!head_seen) begin
                    chk("latency", 32'(cyc - sb[0].acc + 1), 32'(sb[0].lat));
                    head_seen = 1'b1;
                end
                chk("result", bus.o_result, sb[0].res);
                chk("zero", 32'(bus.o_zero), 32'(sb[0].zero));
                chk("illegal", 32'(bus.o_illegal), 32'(sb[0].ill));
                if (bus.i_ready) begin
                    void'(sb.pop_front());
                    head_seen = 1'b0;
                end
            end
        end
    end

    // Random downstream back-pressure, enabled only in the random phase.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) bus.i_ready = (($urandom % 4) != 0);
        end
    end

    initial begin
        int w;
        bus.i_valid    = 1'b1;
        bus.i_alu_ctrl = 4'b0000;
        bus.i_op_a     = 32'h1;
        bus.i_op_b     = 32'h1;
        bus.i_ready    = 1'b1;
        rst            = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        bus.i_valid = 1'b0;
        rst         = 1'b0;
        @(negedge clk);
        chk("rst_valid", 32'(bus.o_valid), 32'd0);
        chk("rst_result", bus.o_result, 32'h0);
        chk("rst_zero", 32'(bus.o_zero), 32'd1);
        chk("rst_illegal", 32'(bus.o_illegal), 32'd0);
        chk("rst_ready", 32'(bus.o_ready), 32'd1);
        tick(1);

        send(4'b0000, 32'hFFFF_FFFF, 32'h1, w);
        send(4'b1000, 32'd5, 32'd7, w);
        send(4'b0010, 32'hFFFF_FFFF, 32'h1, w);
        send(4'b0011, 32'hFFFF_FFFF, 32'h1, w);
        send(4'b0100, 32'hF0F0_F0F0, 32'hFF00_FF00, w);
        send(4'b0110, 32'hF0F0_F0F0, 32'hFF00_FF00, w);
        send(4'b0111, 32'hF0F0_F0F0, 32'hFF00_FF00, w);
        tick(3);

        send(4'b1101, 32'h8000_0000, 32'h24, w);
        repeat (4) begin
            @(negedge clk);
            chk("shift_busy_ready", 32'(bus.o_ready), 32'd0);
        end
        @(negedge clk);
        chk("shift_done_ready", 32'(bus.o_ready), 32'd1);
        @(posedge clk);
        #1;
        send(4'b0101, 32'h8000_0000, 32'h24, w);
        send(4'b0001, 32'h1, 32'd31, w);
        send(4'b0101, 32'hDEAD_BEEF, 32'hFFFF_FFE0, w);
        tick(40);

        bus.i_ready = 1'b0;
        send(4'b0000, 32'd3, 32'd4, w);
        repeat (3) begin
            @(negedge clk);
            chk("bp_ready_low", 32'(bus.o_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        bus.i_ready = 1'b1;
        send(4'b0000, 32'd10, 32'd20, w);
        chk("drain_accept_wait", 32'(w), 32'd0);
        for (int i = 0; i < 4; i++) begin
            send(4'b0000, $urandom, $urandom, w);
            chk("b2b_wait", 32'(w), 32'd0);
        end
        tick(2);

        send(4'b1010, $urandom, $urandom, w);
        send(4'b0110, 32'h1234_0000, 32'h0000_5678, w);
        tick(2);

        send(4'b0001, $urandom, 32'd20, w);
        tick(8);
        rst = 1'b1;
        sb.delete();
        head_seen = 1'b0;
        tick(1);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_ready", 32'(bus.o_ready), 32'd1);
        chk("abort_valid", 32'(bus.o_valid), 32'd0);
        tick(25);
        send(4'b0000, 32'd100, 32'd23, w);
        tick(3);

        rand_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            send(4'($urandom), $urandom, $urandom, w);
            if (($urandom % 4) == 0) tick(1);
        end
        rand_ready = 1'b0;
        @(posedge clk);
        #2;
        bus.i_ready = 1'b1;
        for (int i = 0; i < 200 && sb.size() > 0; i++) @(posedge clk);
        #1;
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
